// File: rtl/aes_pkg.sv
// aes_pkg: shared constants and state encoding for the AES-128 key schedule controller.
package aes_pkg;

  localparam int AES_NRK      = 11;
  localparam int AES_RK_W     = 128;
  localparam int AES_LAST_RND = 10;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    EXPAND,
    READY
  } ks_state_e;

endpackage

// File: rtl/aes_key_sched_ctrl_if.sv
// aes_key_sched_ctrl_if: cipher-key handshake and round-key read port.
interface aes_key_sched_ctrl_if #(
  parameter int IDXW = 4
);

  logic            key_valid;
  logic            key_ready;
  logic [127:0]    key_in;
  logic            rk_ready;
  logic            rd_en;
  logic [IDXW-1:0] rd_idx;
  logic [127:0]    rd_data;
  logic            rd_err;

  modport master (
    output key_valid, key_in, rd_en, rd_idx,
    input  key_ready, rk_ready, rd_data, rd_err
  );

  modport slave (
    input  key_valid, key_in, rd_en, rd_idx,
    output key_ready, rk_ready, rd_data, rd_err
  );

endinterface

// File: rtl/aes_rk_table.sv
// aes_rk_table: round-key register file, one write port and one
// registered read port. Storage is deliberately left unreset.
module aes_rk_table
  import aes_pkg::*;
#(
  parameter int NRK  = AES_NRK,
  parameter int IDXW = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [IDXW-1:0]     widx,
  input  logic [AES_RK_W-1:0] wdata,
  input  logic                re,
  input  logic                rok,
  input  logic [IDXW-1:0]     ridx,
  output logic [AES_RK_W-1:0] rdata
);

  logic [AES_RK_W-1:0] mem_q [NRK];
  logic [AES_RK_W-1:0] rdata_q;
  logic [AES_RK_W-1:0] rdata_d;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[widx] <= wdata;
    end
  end

  // rejected reads return zero; no read leaves the last value in place
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = rok ? mem_q[ridx] : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// aes_key_sched_ctrl: loads the AES-128 expander, captures 11 round keys
// and serves random-access reads. Option: AES_KSCHED_KEYCACHE_EN.
module aes_key_sched_ctrl
  import aes_pkg::*;
#(
  parameter int NRK  = AES_NRK,
  parameter int IDXW = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  aes_key_sched_ctrl_if.slave  bus,
  output logic                 exp_kld,
  output logic [AES_RK_W-1:0]  exp_key,
  input  logic [31:0]          exp_w0,
  input  logic [31:0]          exp_w1,
  input  logic [31:0]          exp_w2,
  input  logic [31:0]          exp_w3,
  output logic                 busy
);

  localparam logic [IDXW-1:0] LAST = IDXW'(AES_LAST_RND);

  ks_state_e           state_q, state_d;
  logic [IDXW-1:0]     cnt_q, cnt_d;
  logic [AES_RK_W-1:0] key_q, key_d;
  logic                vld_q, vld_d;
  logic                rd_err_q, rd_err_d;

  logic accept;
  logic hit;
  logic rd_ok;
  logic key_rdy;
  logic tbl_we;

  assign accept = bus.key_valid & key_rdy;
  assign rd_ok  = vld_q & (bus.rd_idx <= LAST);

`ifdef AES_KSCHED_KEYCACHE_EN
  // a repeat of the resident key keeps the existing table
  assign hit = (state_q == READY) & (bus.key_in == key_q);
`else
  assign hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      key_q    <= '0;
      vld_q    <= 1'b0;
      rd_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      key_q    <= key_d;
      vld_q    <= vld_d;
      rd_err_q <= rd_err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    key_d    = key_q;
    vld_d    = vld_q;
    rd_err_d = bus.rd_en & ~rd_ok;
    unique case (state_q)
      IDLE, READY: begin
        if (accept && !hit) begin
          key_d   = bus.key_in;
          vld_d   = 1'b0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        cnt_d   = '0;
        state_d = EXPAND;
      end
      EXPAND: begin
        if (cnt_q == LAST) begin
          vld_d   = 1'b1;
          state_d = READY;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    key_rdy = 1'b0;
    exp_kld = 1'b0;
    busy    = 1'b0;
    tbl_we  = 1'b0;
    unique case (state_q)
      IDLE, READY: key_rdy = 1'b1;
      LOAD: begin
        exp_kld = 1'b1;
        busy    = 1'b1;
      end
      EXPAND: begin
        busy   = 1'b1;
        tbl_we = 1'b1;
      end
      default: key_rdy = 1'b0;
    endcase
  end

  assign exp_key       = key_q;
  assign bus.key_ready = key_rdy;
  assign bus.rk_ready  = vld_q;
  assign bus.rd_err    = rd_err_q;

  aes_rk_table #(
    .NRK  (NRK),
    .IDXW (IDXW)
  ) u_tbl (
    .clk   (clk),
    .rst   (rst),
    .we    (tbl_we),
    .widx  (cnt_q),
    .wdata ({exp_w0, exp_w1, exp_w2, exp_w3}),
    .re    (bus.rd_en),
    .rok   (rd_ok),
    .ridx  (bus.rd_idx),
    .rdata (bus.rd_data)
  );

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// tb_aes_key_sched_ctrl: directed stimulus with a read scoreboard and a
// stub expander that replays a known schedule for the FIPS-197 key.
module tb_aes_key_sched_ctrl;
  import aes_pkg::*;

  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_RK [11] = '{
    128'h000102030405060708090a0b0c0d0e0f,
    128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
    128'hb692cf0b643dbdf1be9bc5006830b3fe,
    128'hb6ff744ed2c2c9bf6c590cbf0469bf41,
    128'h47f7f7bc95353e03f96c32bcfd058dfd,
    128'h3caaa3e8a99f9deb50f3af57adf622aa,
    128'h5e390f7df7a69296a7553dc10aa31f6b,
    128'h14f9701ae35fe28c440adf4d4ea9c026,
    128'h47438735a41c65b9e016baf4aebf7ad2,
    128'h549932d1f08557681093ed9cbe2c974e,
    128'h13111d7fe3944a17f307a78b4d2b30c5
  };
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K3 = 128'hdeadbeef0123456789abcdeffedcba98;
  localparam logic [127:0] K4 = 128'h00112233445566778899aabbccddeeff;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  aes_key_sched_ctrl_if bus ();

  logic         exp_kld;
  logic         busy;
  logic [127:0] exp_key;
  logic [31:0]  w0, w1, w2, w3;

  aes_key_sched_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .exp_kld (exp_kld),
    .exp_key (exp_key),
    .exp_w0  (w0),
    .exp_w1  (w1),
    .exp_w2  (w2),
    .exp_w3  (w3),
    .busy    (busy)
  );

  function automatic logic [127:0] exp_rk(input logic [127:0] k, input logic [3:0] r);
    if (k == FIPS_KEY) return FIPS_RK[r];
    return k ^ {32{r}};
  endfunction

  // stub expander: round r appears r+1 cycles after the load strobe
  logic [127:0] stub_key = '0;
  logic [3:0]   stub_rnd = '0;
  int           kld_cnt = 0;
  always @(posedge clk) begin
    if (exp_kld) begin
      stub_key <= exp_key;
      stub_rnd <= '0;
      kld_cnt  <= kld_cnt + 1;
    end else if (stub_rnd < 4'd10) begin
      stub_rnd <= stub_rnd + 4'd1;
    end
  end
  assign {w0, w1, w2, w3} = exp_rk(stub_key, stub_rnd);

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // scoreboard: {err, data} expected one cycle after each rd_en
  logic [128:0] sb [$];
  logic         rd_pend = 1'b0;
  logic [127:0] last_data = '0;
  always @(posedge clk) rd_pend <= bus.rd_en;

  always @(negedge clk) begin
    logic [128:0] e;
    if (rst) begin
      last_data = '0;
    end else if (rd_pend) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 128'd1, 128'd0);
      end else begin
        e = sb.pop_front();
        chk("rd_data", bus.rd_data, e[127:0]);
        chk("rd_err", {127'd0, bus.rd_err}, {127'd0, e[128]});
        last_data = e[127:0];
      end
    end else begin
      chk("rd_hold", bus.rd_data, last_data);
      chk("rd_err_idle", {127'd0, bus.rd_err}, 128'd0);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [3:0] idx, input logic err, input logic [127:0] d);
    bus.rd_en  = 1'b1;
    bus.rd_idx = idx;
    sb.push_back({err, d});
    tick;
  endtask

  task automatic rd_idle;
    bus.rd_en = 1'b0;
    tick;
    tick;
  endtask

  task automatic offer(input logic [127:0] k);
    int n;
    bus.key_valid = 1'b1;
    bus.key_in    = k;
    n = 0;
    while (n < 50) begin
      @(negedge clk);
      if (bus.key_ready) break;
      n++;
    end
    if (n >= 50) chk("offer_timeout", 128'd1, 128'd0);
    @(posedge clk);
    #1;
    bus.key_valid = 1'b0;
  endtask

  // waits for rk_ready; optionally fires a read mid-expansion
  task automatic wait_rk(output int cyc, input bit rd_mid);
    int bad;
    cyc = 0;
    bad = 0;
    while (cyc < 40) begin
      bus.rd_en  = rd_mid && (cyc == 3);
      bus.rd_idx = 4'd0;
      if (bus.rd_en) sb.push_back({1'b1, 128'd0});
      tick;
      cyc++;
      if (busy && bus.key_ready) bad++;
      if (bus.rk_ready) break;
    end
    bus.rd_en     = 1'b0;
    bus.key_valid = 1'b0;
    chk("key_ready_busy", 128'(bad), 128'd0);
  endtask

  task automatic check_table(input string name, input logic [127:0] k);
    for (int i = 0; i < 11; i++) rd(4'(i), 1'b0, exp_rk(k, 4'(i)));
    rd_idle;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got hang expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc;
    int k0;
    bus.key_valid = 1'b0;
    bus.key_in    = '0;
    bus.rd_en     = 1'b0;
    bus.rd_idx    = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_key_ready", {127'd0, bus.key_ready}, 128'd1);
    chk("rst_rk_ready", {127'd0, bus.rk_ready}, 128'd0);
    chk("rst_busy", {127'd0, busy}, 128'd0);
    chk("rst_kld", {127'd0, exp_kld}, 128'd0);
    chk("rst_exp_key", exp_key, 128'd0);
    chk("rst_rd_data", bus.rd_data, 128'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    tick;

    // first expansion with a rejected read in the middle
    k0 = kld_cnt;
    offer(FIPS_KEY);
    chk("load_kld", {127'd0, exp_kld}, 128'd1);
    chk("load_busy", {127'd0, busy}, 128'd1);
    chk("load_exp_key", exp_key, FIPS_KEY);
    wait_rk(cyc, 1'b1);
    chk("latency1", 128'(cyc), 128'd12);
    chk("kld_once1", 128'(kld_cnt - k0), 128'd1);
    chk("exp_key_hold", exp_key, FIPS_KEY);

    rd(4'd0, 1'b0, FIPS_RK[0]);
    rd(4'd10, 1'b0, FIPS_RK[10]);
    rd_idle;
    for (int i = 10; i >= 0; i--) rd(4'(i), 1'b0, FIPS_RK[i]);
    rd_idle;
    rd(4'd11, 1'b1, 128'd0);
    rd(4'd15, 1'b1, 128'd0);
    rd(4'd3, 1'b0, FIPS_RK[3]);
    rd_idle;

    // key accepted alongside a read; then a different key held during busy
    bus.key_valid = 1'b1;
    bus.key_in    = K2;
    rd(4'd5, 1'b0, FIPS_RK[5]);
    bus.rd_en     = 1'b0;
    bus.key_in    = K3;
    chk("rk_drop", {127'd0, bus.rk_ready}, 128'd0);
    k0 = kld_cnt;
    wait_rk(cyc, 1'b0);
    chk("latency2", 128'(cyc), 128'd12);
    chk("kld_once2", 128'(kld_cnt - k0), 128'd1);
    chk("exp_key_k2", exp_key, K2);
    check_table("tbl_k2", K2);

    // reset in the middle of an expansion
    offer(K3);
    repeat (6) tick;
    rst = 1'b1;
    #1;
    chk("mid_rst_kld", {127'd0, exp_kld}, 128'd0);
    chk("mid_rst_rk", {127'd0, bus.rk_ready}, 128'd0);
    chk("mid_rst_kr", {127'd0, bus.key_ready}, 128'd1);
    chk("mid_rst_busy", {127'd0, busy}, 128'd0);
    tick;
    rst = 1'b0;
    tick;
    rd(4'd0, 1'b1, 128'd0);
    rd_idle;
    offer(K4);
    wait_rk(cyc, 1'b0);
    chk("latency3", 128'(cyc), 128'd12);
    check_table("tbl_k4", K4);

    // same key re-offered in READY
    k0 = kld_cnt;
    offer(K4);
`ifdef AES_KSCHED_KEYCACHE_EN
    cyc = 0;
    for (int i = 0; i < 14; i++) begin
      if (!bus.rk_ready) cyc++;
      tick;
    end
    chk("cache_rk_hold", 128'(cyc), 128'd0);
    chk("cache_no_kld", 128'(kld_cnt - k0), 128'd0);
    rd(4'd7, 1'b0, exp_rk(K4, 4'd7));
    rd_idle;
`else
    wait_rk(cyc, 1'b0);
    chk("same_key_latency", 128'(cyc), 128'd12);
    chk("same_key_kld", 128'(kld_cnt - k0), 128'd1);
`endif

    k0 = kld_cnt;
    offer(FIPS_KEY);
    wait_rk(cyc, 1'b0);
    chk("latency4", 128'(cyc), 128'd12);
    chk("kld_once4", 128'(kld_cnt - k0), 128'd1);
    rd(4'd10, 1'b0, FIPS_RK[10]);
    rd_idle;

    chk("sb_drained", 128'(sb.size()), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
